// File: rtl/serial_pkg.sv
// Shared definitions for the serial parity transmitter and its matching receiver:
// state encoding, default frame width and parity mode constants.
package serial_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } tx_state_t;

    localparam int DEFAULT_DATA_W  = 8;

    localparam int PARITY_EVEN     = 0;
    localparam int PARITY_ODD_MODE = 1;

    // Starting value of the running XOR so the final bit yields the chosen parity
    function automatic logic parity_seed(input int mode);
        return (mode != PARITY_EVEN);
    endfunction

endpackage

// File: rtl/serial_parity_tx_if.sv
// Word-in / bit-out bundle of the serial parity transmitter.
// master = word producer and serial line observer, slave = the transmitter.
import serial_pkg::*;

interface serial_parity_tx_if #(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_start;
    logic              par_slot;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, frame_start, par_slot, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, frame_start, par_slot, busy
    );

endinterface

// File: rtl/serial_parity_tx_parity_acc.sv
// One-bit running XOR accumulator. A clear loads the seed (parity mode),
// each enabled cycle folds in one serial bit. parity_nxt exposes the value
// the accumulator would take this cycle so a caller can emit it without delay.
import serial_pkg::*;

module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic seed,
    input  logic en,
    input  logic bit_in,
    output logic parity,
    output logic parity_nxt
);

    assign parity_nxt = parity ^ bit_in;

    // Clear has priority over accumulate so a new frame always starts from the seed
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (clear) begin
            parity <= seed;
        end else if (en) begin
            parity <= parity_nxt;
        end
    end

endmodule

// File: rtl/serial_parity_tx.sv
// Serialises a parallel word LSB-first, then appends a parity bit.
// All serial-side outputs are registered and computed one cycle ahead, so a word
// accepted at edge N shows data bit 0 during cycle N+1 and parity during N+1+DATA_W.
// The parity cycle also accepts the next word, allowing gap-free back-to-back frames.
module serial_parity_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int PARITY_ODD = PARITY_EVEN
) (
    input  logic               clk,
    input  logic               rst,
    serial_parity_tx_if.slave  bus
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             SEED     = parity_seed(PARITY_ODD);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              acc;
    logic              acc_nxt;
    logic              shifting;

    assign accept   = bus.in_valid & bus.in_ready;
    assign shifting = (state == SHIFT);

    parity_acc u_parity_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .seed       (SEED),
        .en         (shifting),
        .bit_in     (shreg[0]),
        .parity     (acc),
        .parity_nxt (acc_nxt)
    );

    // Frame FSM: state, shift register, bit counter and look-ahead output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            cnt             <= '0;
            bus.ser_out     <= 1'b0;
            bus.ser_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.par_slot    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE, PARITY: begin
                    if (accept) begin
                        state           <= SHIFT;
                        shreg           <= bus.in_data;
                        cnt             <= '0;
                        bus.ser_out     <= bus.in_data[0];
                        bus.ser_valid   <= 1'b1;
                        bus.frame_start <= 1'b1;
                        bus.par_slot    <= 1'b0;
                        bus.busy        <= 1'b1;
                        bus.in_ready    <= 1'b0;
                    end else begin
                        state           <= IDLE;
                        bus.ser_out     <= 1'b0;
                        bus.ser_valid   <= 1'b0;
                        bus.frame_start <= 1'b0;
                        bus.par_slot    <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.in_ready    <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg           <= shreg >> 1;
                    bus.frame_start <= 1'b0;
                    bus.ser_valid   <= 1'b1;
                    bus.busy        <= 1'b1;
                    if (cnt == LAST_BIT) begin
                        state        <= PARITY;
                        bus.ser_out  <= acc_nxt;
                        bus.par_slot <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        bus.ser_out  <= shreg[1];
                        bus.par_slot <= 1'b0;
                        bus.in_ready <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.ser_out     <= 1'b0;
                    bus.ser_valid   <= 1'b0;
                    bus.frame_start <= 1'b0;
                    bus.par_slot    <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.in_ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule
